serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor; computes diff = a - b one bit per clock, LSB first, through a single full-adder cell.
- Uses two's-complement subtraction: a + ~b + 1.
- Inverse arithmetic companion to the combinational full_adder cell; intended for area-constrained datapaths that can tolerate WIDTH-cycle latency.
- start/busy/done handshake toward the controlling logic.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/serial_subtractor_full_adder.sv | 17 +
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//   - FSM state encodings (IDLE, SHIFT, DONE)
//   - cnt_width(): width of the bit counter, clog2(w+1)
package serial_subtractor_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Smallest r with 2**r >= w+1, so the counter can represent 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < (64'(w) + 64'd1)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Handshake and operand/result bundle of the bit-serial subtractor.
//   start, a, b            : request and operands (controller -> subtractor)
//   busy, done, diff, borrow: status and result   (subtractor -> controller)
//   Modports: master = controlling logic, slave = subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );

endinterface

// File: rtl/serial_subtractor_full_adder.sv
// full_adder
//   Single-bit combinational full adder.
//   a, b, ci : addend bits and carry in
//   so       : sum out
//   co       : carry out (majority of a, b, ci)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic so,
    output logic co
);

    assign so = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per
//   clock through a single full adder computing a + ~b + 1.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_subtractor_if
//            start (sampled in IDLE), a/b (captured on accepted start),
//            busy (SHIFT or DONE), done (one-cycle result-valid pulse),
//            diff (a - b mod 2**WIDTH), borrow (a < b unsigned)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_next;
    logic             carry;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt;
    logic             sum_bit;
    logic             carry_out;

    full_adder u_full_adder (
        .a  (a_sr[0]),
        .b  (~b_sr[0]),
        .ci (carry),
        .so (sum_bit),
        .co (carry_out)
    );

    // Sum bit enters at the MSB; written as shift-then-overwrite so that
    // WIDTH=1 needs no zero-width slice.
    always_comb begin
        diff_next            = diff_r >> 1;
        diff_next[WIDTH-1]   = sum_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_r   <= '0;
            carry    <= 1'b0;
            borrow_r <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_r <= diff_next;
                    carry  <= carry_out;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // No carry out of the MSB of a + ~b + 1 means a < b.
                        borrow_r <= ~carry_out;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state == SHIFT) || (state == DONE);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
//   Expected results are pushed to a scoreboard queue when an operation is
//   started and popped when the DUT raises done.
module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
    } exp8_t;

    typedef struct packed {
        logic diff;
        logic borrow;
    } exp1_t;

    exp8_t sb8[$];
    exp1_t sb1[$];

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request into the 8-bit DUT; returns 1 ns after the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        exp8_t e;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        sb8.push_back(e);
        bus8.a     = av;
        bus8.b     = bv;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
    endtask

    task automatic issue1(input logic av, input logic bv);
        exp1_t e;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        sb1.push_back(e);
        bus1.a     = av;
        bus1.b     = bv;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
    endtask

    // Counts edges from the current sample until done is seen, bounded.
    task automatic wait_done(input bit w1, output int edges, output bit timeout);
        timeout = 1'b1;
        edges   = 0;
        for (int i = 0; i < 40; i++) begin
            if ((w1 ? bus1.done : bus8.done) === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_async_w8: got %0h expected 0",
                     {bus8.busy, bus8.done, bus8.diff, bus8.borrow});
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.diff, bus1.borrow} !== 4'd0) begin
            failures++;
            $display("FAIL reset_async_w1: got %0h expected 0",
                     {bus1.busy, bus1.done, bus1.diff, bus1.borrow});
        end
        bus8.start = 1'b1;
        step();
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_held_w8: got %0h expected 0",
                     {bus8.busy, bus8.done, bus8.diff, bus8.borrow});
        end
        bus8.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int    first;
        int    last;
        int    busy_n;
        exp8_t e;
        first  = -1;
        last   = -1;
        busy_n = 0;
        issue8(8'd5, 8'd3);
        for (int i = 0; i < 12; i++) begin
            if (bus8.busy === 1'b1) busy_n++;
            if (bus8.done === 1'b1) begin
                if (first < 0) begin
                    first = i;
                    if (sb8.size() > 0) begin
                        e = sb8.pop_front();
                        checks++;
                        if (bus8.diff !== e.diff) begin
                            failures++;
                            $display("FAIL basic_diff: got %0h expected %0h", bus8.diff, e.diff);
                        end
                        checks++;
                        if (bus8.borrow !== e.borrow) begin
                            failures++;
                            $display("FAIL basic_borrow: got %0b expected %0b", bus8.borrow, e.borrow);
                        end
                    end
                end
                last = i;
            end
            if (i < 11) step();
        end
        if (first < 0 && sb8.size() > 0) void'(sb8.pop_front());
        checks++;
        if (first !== 8) begin
            failures++;
            $display("FAIL basic_done_rise: got edge %0d expected edge 8", first);
        end
        checks++;
        if (last !== 8) begin
            failures++;
            $display("FAIL basic_done_fall: last high after edge %0d expected 8 (low from edge 9)", last);
        end
        checks++;
        if (busy_n !== 9) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", busy_n);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        int         edges;
        bit         to;
        exp8_t      e;
        ta = '{8'd3, 8'd0, 8'hFF};
        tb = '{8'd5, 8'd1, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            issue8(ta[i], tb[i]);
            wait_done(1'b0, edges, to);
            e = sb8.pop_front();
            checks++;
            if (to || edges !== 8) begin
                failures++;
                $display("FAIL corner_latency[%0d]: got %0d edges (timeout=%0b) expected 8", i, edges, to);
            end
            checks++;
            if (bus8.diff !== e.diff) begin
                failures++;
                $display("FAIL corner_diff[%0d]: got %0h expected %0h", i, bus8.diff, e.diff);
            end
            checks++;
            if (bus8.borrow !== e.borrow) begin
                failures++;
                $display("FAIL corner_borrow[%0d]: got %0b expected %0b", i, bus8.borrow, e.borrow);
            end
            step();
            checks++;
            if ({bus8.done, bus8.diff, bus8.borrow} !== {1'b0, e.diff, e.borrow}) begin
                failures++;
                $display("FAIL corner_hold[%0d]: got done=%0b diff=%0h borrow=%0b expected done=0 diff=%0h borrow=%0b",
                         i, bus8.done, bus8.diff, bus8.borrow, e.diff, e.borrow);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[30];
        logic [7:0] bv[30];
        int         done_at[$];
        int         idle_between;
        exp8_t      e;
        exp8_t      x;
        idle_between = 0;
        for (int i = 0; i < 30; i++) begin
            av[i] = 8'($urandom_range(255));
            bv[i] = 8'($urandom_range(255));
        end
        bus8.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus8.a = av[i];
            bus8.b = bv[i];
            if (i % 10 == 0) begin
                x.diff   = av[i] - bv[i];
                x.borrow = (av[i] < bv[i]);
                sb8.push_back(x);
            end
            step();
            if (bus8.done === 1'b1) begin
                done_at.push_back(i);
                if (sb8.size() > 0) begin
                    e = sb8.pop_front();
                    checks++;
                    if ({bus8.diff, bus8.borrow} !== {e.diff, e.borrow}) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                                 done_at.size() - 1, bus8.diff, bus8.borrow, e.diff, e.borrow);
                    end
                end
            end
            if (done_at.size() == 1 && bus8.busy === 1'b0) idle_between++;
        end
        bus8.start = 1'b0;
        while (sb8.size() > 0) void'(sb8.pop_front());
        checks++;
        if (done_at.size() != 3 || done_at[0] != 8 || done_at[1] != 18 || done_at[2] != 28) begin
            failures++;
            $display("FAIL b2b_done_times: got %0d pulses %p expected edges 8 18 28", done_at.size(), done_at);
        end
        checks++;
        if (idle_between !== 1) begin
            failures++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles expected 1", idle_between);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit    done_seen;
        int    edges;
        bit    to;
        exp8_t e;
        bus8.a     = 8'h55;
        bus8.b     = 8'h22;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        repeat (4) step();
        checks++;
        if (bus8.busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre_busy: got %0b expected 1", bus8.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow} !== 11'd0) begin
            failures++;
            $display("FAIL midreset_clear: got %0h expected 0",
                     {bus8.busy, bus8.done, bus8.diff, bus8.borrow});
        end
        #2;
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            step();
            if (bus8.done === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_done: got done pulse expected none");
        end
        issue8(8'd10, 8'd4);
        wait_done(1'b0, edges, to);
        e = sb8.pop_front();
        checks++;
        if (to || {bus8.diff, bus8.borrow} !== {e.diff, e.borrow}) begin
            failures++;
            $display("FAIL midreset_fresh: got diff=%0h borrow=%0b timeout=%0b expected diff=%0h borrow=%0b",
                     bus8.diff, bus8.borrow, to, e.diff, e.borrow);
        end
        step();
    endtask

    task automatic test_random();
        int    edges;
        bit    to;
        exp8_t e;
        for (int n = 0; n < 1000; n++) begin
            issue8(8'($urandom_range(255)), 8'($urandom_range(255)));
            wait_done(1'b0, edges, to);
            e = sb8.pop_front();
            checks++;
            if (to || edges !== 8) begin
                failures++;
                $display("FAIL rand_latency[%0d]: got %0d edges (timeout=%0b) expected 8", n, edges, to);
            end
            checks++;
            if ({bus8.diff, bus8.borrow} !== {e.diff, e.borrow}) begin
                failures++;
                $display("FAIL rand_result[%0d]: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                         n, bus8.diff, bus8.borrow, e.diff, e.borrow);
            end
            step();
            checks++;
            if (bus8.done !== 1'b0) begin
                failures++;
                $display("FAIL rand_done_width[%0d]: got done=%0b expected 0", n, bus8.done);
            end
        end
    endtask

    task automatic test_width1();
        logic  ta[2];
        logic  tb[2];
        int    edges;
        bit    to;
        exp1_t e;
        ta = '{1'b0, 1'b1};
        tb = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue1(ta[i], tb[i]);
            wait_done(1'b1, edges, to);
            e = sb1.pop_front();
            checks++;
            if (to || edges !== 1) begin
                failures++;
                $display("FAIL w1_latency[%0d]: got %0d edges (timeout=%0b) expected 1", i, edges, to);
            end
            checks++;
            if ({bus1.diff, bus1.borrow} !== {e.diff, e.borrow}) begin
                failures++;
                $display("FAIL w1_result[%0d]: got diff=%0b borrow=%0b expected diff=%0b borrow=%0b",
                         i, bus1.diff, bus1.borrow, e.diff, e.borrow);
            end
            step();
            checks++;
            if (bus1.done !== 1'b0) begin
                failures++;
                $display("FAIL w1_done_fall[%0d]: got done=%0b expected 0", i, bus1.done);
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
